// File: rtl/hdcpu_seq_ctrl.sv
// Hardwired sequencing control unit for the HD-CPU datapath: generates its own
// W1..W3 beats, tracks the ST0 phase, and decodes console mode and opcode into strobes.
module hdcpu_seq_ctrl #(
    parameter int OP_W    = 4,
    parameter int SEL_W   = 4,
    parameter int ALU_S_W = 4
) (
    input  logic               T3,
    input  logic               CLR,
    input  logic               GO,
    input  logic               STEP,
    input  logic [2:0]         SW,
    input  logic [OP_W-1:0]    IR,
    input  logic               C,
    input  logic               Z,
    output logic [2:0]         W,
    output logic               ST0,
    output logic               RUNNING,
    output logic               STOP,
    output logic               LDC,
    output logic               LDZ,
    output logic               CIN,
    output logic               M,
    output logic               ABUS,
    output logic               DRW,
    output logic               PCINC,
    output logic               LPC,
    output logic               LAR,
    output logic               PCADD,
    output logic               ARINC,
    output logic               SELCTL,
    output logic               MEMW,
    output logic               LIR,
    output logic               SBUS,
    output logic               MBUS,
    output logic [ALU_S_W-1:0] S,
    output logic [SEL_W-1:0]   SEL,
    output logic [1:0]         dbg_state
);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HALT = 2'd2} state_t;

    state_t     state;
    logic [2:0] sw_q;
    logic [3:0] opc;
    logic       sw_ok;
    logic       short_b;
    logic       long_b;
    logic       halt_b;
    logic       eoi;
    logic [2:0] nxt_w;

    assign opc       = IR[OP_W-1 -: 4];
    assign sw_ok     = (SW <= 3'd4);
    assign RUNNING   = (state == RUN);
    assign STOP      = (state != RUN) || !sw_ok;
    assign dbg_state = state;

    // GO is a level request with no acknowledge: it is acted on only when sampled
    // high on T3 while IDLE with a legal console mode, and ignored in every other case.
    always_comb begin
        LDC = 1'b0; LDZ = 1'b0; CIN = 1'b0; M = 1'b0; ABUS = 1'b0; DRW = 1'b0;
        PCINC = 1'b0; LPC = 1'b0; LAR = 1'b0; PCADD = 1'b0; ARINC = 1'b0;
        SELCTL = 1'b0; MEMW = 1'b0; LIR = 1'b0; SBUS = 1'b0; MBUS = 1'b0;
        S = '0; SEL = '0;
        short_b = 1'b0; long_b = 1'b0; halt_b = 1'b0;
        if (state == RUN) begin
            case (SW)
                3'd0: begin
                    if (!ST0) begin
                        SBUS = 1'b1; LPC = 1'b1; short_b = 1'b1;
                    end else if (W[0]) begin
                        LIR = 1'b1; PCINC = 1'b1;
                    end else if (W[1]) begin
                        case (opc)
                            4'b0001: begin S = ALU_S_W'(4'b1001); CIN = 1'b1; ABUS = 1'b1;
                                           DRW = 1'b1; LDC = 1'b1; LDZ = 1'b1; end
                            4'b0010: begin S = ALU_S_W'(4'b0110); ABUS = 1'b1; DRW = 1'b1;
                                           LDC = 1'b1; LDZ = 1'b1; end
                            4'b0011: begin M = 1'b1; S = ALU_S_W'(4'b1011); ABUS = 1'b1;
                                           DRW = 1'b1; LDZ = 1'b1; end
                            4'b0100: begin ABUS = 1'b1; DRW = 1'b1; LDC = 1'b1; LDZ = 1'b1; end
                            4'b0101: begin M = 1'b1; S = ALU_S_W'(4'b1010); ABUS = 1'b1;
                                           LAR = 1'b1; long_b = 1'b1; end
                            4'b0110: begin M = 1'b1; S = ALU_S_W'(4'b1111); ABUS = 1'b1;
                                           LAR = 1'b1; long_b = 1'b1; end
                            4'b0111: PCADD = C;
                            4'b1000: PCADD = Z;
                            4'b1001: begin M = 1'b1; S = ALU_S_W'(4'b1111); ABUS = 1'b1;
                                           LPC = 1'b1; end
                            4'b1110: halt_b = 1'b1;
                            default: ;
                        endcase
                    end else if (W[2]) begin
                        if (opc == 4'b0101) begin
                            MBUS = 1'b1; DRW = 1'b1;
                        end else if (opc == 4'b0110) begin
                            M = 1'b1; S = ALU_S_W'(4'b1010); ABUS = 1'b1; MEMW = 1'b1;
                        end
                    end
                end
                3'd1: begin
                    short_b = 1'b1; SBUS = 1'b1;
                    if (!ST0) LAR = 1'b1;
                    else begin MEMW = 1'b1; ARINC = 1'b1; end
                end
                3'd2: begin
                    short_b = 1'b1;
                    if (!ST0) begin SBUS = 1'b1; LAR = 1'b1; end
                    else begin MBUS = 1'b1; ARINC = 1'b1; end
                end
                3'd3: begin
                    SELCTL = 1'b1;
                    SEL = W[0] ? SEL_W'(4'b0001) : SEL_W'(4'b1011);
                end
                3'd4: begin
                    SELCTL = 1'b1; SBUS = 1'b1; DRW = 1'b1;
                    if (W[0]) SEL = ST0 ? SEL_W'(4'b1001) : SEL_W'(4'b0011);
                    else      SEL = ST0 ? SEL_W'(4'b1110) : SEL_W'(4'b0100);
                end
                default: ;
            endcase
        end
    end

    // An instruction ends on whichever beat hands control back to W1.
    assign eoi   = (W[0] && short_b) || (W[1] && !long_b) || W[2];
    assign nxt_w = short_b          ? 3'b001 :
                   W[0]             ? 3'b010 :
                   (W[1] && long_b) ? 3'b100 : 3'b001;

    always_ff @(posedge T3 or negedge CLR) begin
        if (!CLR) begin
            state <= IDLE;
            W     <= 3'b001;
            ST0   <= 1'b0;
            sw_q  <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    W <= 3'b001;
                    if (SW != sw_q) begin
                        ST0  <= 1'b0;
                        sw_q <= SW;
                    end
                    if (GO && sw_ok) state <= RUN;
                end
                RUN: begin
                    if (!sw_ok) begin
                        state <= IDLE;
                        W     <= 3'b001;
                    end else begin
                        sw_q <= SW;
                        W    <= nxt_w;
                        if (eoi) begin
                            ST0 <= 1'b1;
                            if (halt_b)    state <= HALT;
                            else if (STEP) state <= IDLE;
                        end
                    end
                end
                HALT:    W <= 3'b001;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hdcpu_seq_ctrl.sv
// Randomized bench for hdcpu_seq_ctrl: an operation-level reference model queues the
// expected output bundle each cycle and a negedge monitor pops and compares it.
module tb_hdcpu_seq_ctrl;

  logic       T3 = 1'b0;
  logic       CLR = 1'b0;
  logic       GO = 1'b0;
  logic       STEP = 1'b0;
  logic [2:0] SW = 3'd0;
  logic [3:0] IR = 4'd0;
  logic       C = 1'b0;
  logic       Z = 1'b0;
  logic [2:0] W;
  logic       ST0, RUNNING, STOP;
  logic       LDC, LDZ, CIN, M, ABUS, DRW, PCINC, LPC, LAR, PCADD, ARINC, SELCTL, MEMW, LIR, SBUS, MBUS;
  logic [3:0] S, SEL;
  logic [1:0] dbg_state;

  // clock / reset block
  always #5 T3 = ~T3;

  hdcpu_seq_ctrl #(.OP_W(4), .SEL_W(4), .ALU_S_W(4)) dut (
    .T3(T3), .CLR(CLR), .GO(GO), .STEP(STEP), .SW(SW), .IR(IR), .C(C), .Z(Z),
    .W(W), .ST0(ST0), .RUNNING(RUNNING), .STOP(STOP),
    .LDC(LDC), .LDZ(LDZ), .CIN(CIN), .M(M), .ABUS(ABUS), .DRW(DRW), .PCINC(PCINC),
    .LPC(LPC), .LAR(LAR), .PCADD(PCADD), .ARINC(ARINC), .SELCTL(SELCTL), .MEMW(MEMW),
    .LIR(LIR), .SBUS(SBUS), .MBUS(MBUS), .S(S), .SEL(SEL), .dbg_state(dbg_state)
  );

  localparam logic [15:0] F_LDC = 16'h8000, F_LDZ = 16'h4000, F_CIN = 16'h2000, F_M = 16'h1000;
  localparam logic [15:0] F_ABUS = 16'h0800, F_DRW = 16'h0400, F_PCINC = 16'h0200, F_LPC = 16'h0100;
  localparam logic [15:0] F_LAR = 16'h0080, F_PCADD = 16'h0040, F_ARINC = 16'h0020, F_SELCTL = 16'h0010;
  localparam logic [15:0] F_MEMW = 16'h0008, F_LIR = 16'h0004, F_SBUS = 16'h0002, F_MBUS = 16'h0001;

  logic [31:0] act;
  assign act = {dbg_state, W, ST0, RUNNING, STOP,
                LDC, LDZ, CIN, M, ABUS, DRW, PCINC, LPC, LAR, PCADD, ARINC, SELCTL, MEMW, LIR, SBUS, MBUS,
                S, SEL};

  logic [31:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int cyc_now = 0;

  // reference model: mode 0 idle, 1 run, 2 halt; an operation is a list of beats
  logic [1:0]  m_mode;
  int          m_pos;
  logic        m_st0;
  logic [2:0]  m_swl;
  logic [23:0] plan [0:2];
  int          plan_n;
  logic        plan_halt;

  function automatic logic [23:0] bt(input logic [15:0] f, input logic [3:0] s, input logic [3:0] sel);
    return {f, s, sel};
  endfunction

  task automatic plan_op(input logic [2:0] sw, input logic st0, input logic [3:0] op,
                         input logic c, input logic z);
    plan[0] = '0; plan[1] = '0; plan[2] = '0; plan_n = 1; plan_halt = 1'b0;
    case (sw)
      3'd0: begin
        if (!st0) plan[0] = bt(F_SBUS | F_LPC, 4'd0, 4'd0);
        else begin
          plan[0] = bt(F_LIR | F_PCINC, 4'd0, 4'd0);
          plan_n = 2;
          case (op)
            4'd1: plan[1] = bt(F_CIN | F_ABUS | F_DRW | F_LDC | F_LDZ, 4'b1001, 4'd0);
            4'd2: plan[1] = bt(F_ABUS | F_DRW | F_LDC | F_LDZ, 4'b0110, 4'd0);
            4'd3: plan[1] = bt(F_M | F_ABUS | F_DRW | F_LDZ, 4'b1011, 4'd0);
            4'd4: plan[1] = bt(F_ABUS | F_DRW | F_LDC | F_LDZ, 4'b0000, 4'd0);
            4'd5: begin
              plan[1] = bt(F_M | F_ABUS | F_LAR, 4'b1010, 4'd0);
              plan[2] = bt(F_MBUS | F_DRW, 4'd0, 4'd0);
              plan_n = 3;
            end
            4'd6: begin
              plan[1] = bt(F_M | F_ABUS | F_LAR, 4'b1111, 4'd0);
              plan[2] = bt(F_M | F_ABUS | F_MEMW, 4'b1010, 4'd0);
              plan_n = 3;
            end
            4'd7: plan[1] = c ? bt(F_PCADD, 4'd0, 4'd0) : 24'd0;
            4'd8: plan[1] = z ? bt(F_PCADD, 4'd0, 4'd0) : 24'd0;
            4'd9: plan[1] = bt(F_M | F_ABUS | F_LPC, 4'b1111, 4'd0);
            4'd14: plan_halt = 1'b1;
            default: ;
          endcase
        end
      end
      3'd1: plan[0] = st0 ? bt(F_SBUS | F_MEMW | F_ARINC, 4'd0, 4'd0) : bt(F_SBUS | F_LAR, 4'd0, 4'd0);
      3'd2: plan[0] = st0 ? bt(F_MBUS | F_ARINC, 4'd0, 4'd0) : bt(F_SBUS | F_LAR, 4'd0, 4'd0);
      3'd3: begin
        plan[0] = bt(F_SELCTL, 4'd0, 4'b0001);
        plan[1] = bt(F_SELCTL, 4'd0, 4'b1011);
        plan_n = 2;
      end
      default: begin
        plan[0] = bt(F_SELCTL | F_SBUS | F_DRW, 4'd0, st0 ? 4'b1001 : 4'b0011);
        plan[1] = bt(F_SELCTL | F_SBUS | F_DRW, 4'd0, st0 ? 4'b1110 : 4'b0100);
        plan_n = 2;
      end
    endcase
  endtask

  task automatic model_reset();
    m_mode = 2'd0; m_pos = 0; m_st0 = 1'b0; m_swl = 3'd0;
  endtask

  // advance the model across one T3 edge using the inputs that were stable before it
  task automatic model_edge();
    case (m_mode)
      2'd0: begin
        if (SW != m_swl) begin m_st0 = 1'b0; m_swl = SW; end
        if (GO && SW <= 3'd4) begin m_mode = 2'd1; m_pos = 0; end
      end
      2'd1: begin
        m_pos++;
        if (m_pos == plan_n) begin
          m_pos = 0;
          m_st0 = 1'b1;
          if (plan_halt) m_mode = 2'd2;
          else if (STEP) m_mode = 2'd0;
        end
      end
      default: ;
    endcase
  endtask

  // driver
  initial begin : driver
    logic        clr_now;
    logic        clr_prev;
    logic [31:0] e;
    int          r;
    int          op;
    model_reset();
    plan_op(3'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    clr_prev = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge T3);
      if (!clr_prev) model_edge();
      #1;
      cyc_now = cyc;
      clr_now = (cyc < 3) || ($urandom_range(0, 79) == 0);
      if (clr_now) begin
        CLR = 1'b0;
        model_reset();
      end else begin
        CLR = 1'b1;
      end
      GO   = ($urandom_range(0, 1) == 1);
      STEP = ($urandom_range(0, 2) == 0);
      if (m_mode != 2'd1 && $urandom_range(0, 3) == 0) begin
        r  = $urandom_range(0, 9);
        SW = (r < 5) ? 3'(r) : (r < 8) ? 3'd0 : 3'(5 + $urandom_range(0, 2));
      end
      if (m_mode != 2'd1 || m_pos == 0) begin
        op = $urandom_range(0, 15);
        if (op == 14 && $urandom_range(0, 3) != 0) op = 1;
        IR = 4'(op);
        C  = ($urandom_range(0, 1) == 1);
        Z  = ($urandom_range(0, 1) == 1);
      end
      if (m_mode == 2'd1) begin
        if (m_pos == 0) plan_op(SW, m_st0, IR, C, Z);
        e = {2'd1, 3'b001 << m_pos, m_st0, 1'b1, 1'b0, plan[m_pos]};
      end else begin
        e = {m_mode, 3'b001, m_st0, 1'b0, 1'b1, 24'd0};
      end
      exp_q.push_back(e);
      clr_prev = clr_now;
    end
    repeat (3) @(negedge T3);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // scoreboard monitor
  always @(negedge T3) begin : monitor
    logic [31:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL outputs cyc=%0d got=%h exp=%h (state,W,ST0,RUN,STOP,strobes,S,SEL)",
                 cyc_now, act, e);
      end
    end
  end

endmodule
